// File: rtl/hockey_input_arbiter.sv
// Debounces both player buttons, turns each press into a captured {y, dir} event and
// serialises the two players onto one valid/accept request channel with round-robin ties.
//
// state | meaning
// EMPTY | request register holds nothing, req_valid=0
// FULL  | request register holds an event, payload frozen until accept
module hockey_input_arbiter #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int Y_MAX           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_a_raw_i,
    input  logic       btn_b_raw_i,
    input  logic [1:0] dir_a_i,
    input  logic [1:0] dir_b_i,
    input  logic [2:0] y_a_i,
    input  logic [2:0] y_b_i,
    input  logic       flush_i,
    input  logic       accept_i,
    output logic       req_valid_o,
    output logic       req_player_o,
    output logic [2:0] req_y_o,
    output logic [1:0] req_dir_o,
    output logic       req_y_ok_o,
    output logic       drop_a_o,
    output logic       drop_b_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]      Y_MAX_L  = 3'(Y_MAX);

    typedef enum logic {EMPTY, FULL} state_t;

    // index 0 = player A, index 1 = player B throughout
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            deb_q, deb_d;
    logic [1:0]            deb_dly_q;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            slot_vld_q, slot_vld_d;
    logic [1:0][4:0]       slot_q, slot_d;
    logic [1:0][4:0]       slot_in;
    logic [1:0]            press;
    logic [1:0]            grant;
    logic [1:0]            drop_q, drop_d;
    logic                  rr_last_q, rr_last_d;
    logic                  load_en;
    state_t                state_q, state_d;
    logic                  player_q, player_d;
    logic [2:0]            y_q, y_d;
    logic [1:0]            dir_q, dir_d;
    logic                  y_ok_q, y_ok_d;
    logic [4:0]            sel_slot;

    assign slot_in[0] = {y_a_i, (dir_a_i == 2'b11) ? 2'b00 : dir_a_i};
    assign slot_in[1] = {y_b_i, (dir_b_i == 2'b11) ? 2'b00 : dir_b_i};
    assign press      = deb_q & ~deb_dly_q;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // rr_last_q: 0 = A won the last tie, 1 = B won it
    always_comb begin
        load_en   = !flush_i && ((state_q == EMPTY) || accept_i);
        grant[0]  = load_en && slot_vld_q[0] && (!slot_vld_q[1] || rr_last_q);
        grant[1]  = load_en && slot_vld_q[1] && (!slot_vld_q[0] || !rr_last_q);
        rr_last_d = (load_en && (&slot_vld_q)) ? grant[1] : rr_last_q;
    end

    always_comb begin
        slot_vld_d = slot_vld_q;
        slot_d     = slot_q;
        drop_d     = '0;
        for (int i = 0; i < 2; i++) begin
            if (flush_i) begin
                slot_vld_d[i] = 1'b0;
            end else if (press[i]) begin
                if (slot_vld_q[i] && !grant[i]) begin
                    drop_d[i] = 1'b1;
                end else begin
                    slot_d[i]     = slot_in[i];
                    slot_vld_d[i] = 1'b1;
                end
            end else if (grant[i]) begin
                slot_vld_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        player_d = player_q;
        y_d      = y_q;
        dir_d    = dir_q;
        y_ok_d   = y_ok_q;
        sel_slot = grant[1] ? slot_q[1] : slot_q[0];
        if (flush_i) begin
            state_d  = EMPTY;
            player_d = 1'b0;
            y_d      = '0;
            dir_d    = '0;
            y_ok_d   = 1'b0;
        end else if (load_en) begin
            if (|grant) begin
                state_d  = FULL;
                player_d = grant[1];
                y_d      = sel_slot[4:2];
                dir_d    = sel_slot[1:0];
                y_ok_d   = (sel_slot[4:2] <= Y_MAX_L);
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_dly_q  <= '0;
            cnt_q      <= '0;
            slot_vld_q <= '0;
            slot_q     <= '0;
            drop_q     <= '0;
            rr_last_q  <= 1'b1;
            state_q    <= EMPTY;
            player_q   <= 1'b0;
            y_q        <= '0;
            dir_q      <= '0;
            y_ok_q     <= 1'b0;
        end else begin
            sync1_q    <= {btn_b_raw_i, btn_a_raw_i};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_dly_q  <= deb_q;
            cnt_q      <= cnt_d;
            slot_vld_q <= slot_vld_d;
            slot_q     <= slot_d;
            drop_q     <= drop_d;
            rr_last_q  <= rr_last_d;
            state_q    <= state_d;
            player_q   <= player_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            y_ok_q     <= y_ok_d;
        end
    end

    assign req_valid_o  = (state_q == FULL);
    assign req_player_o = player_q;
    assign req_y_o      = y_q;
    assign req_dir_o    = dir_q;
    assign req_y_ok_o   = y_ok_q;
    assign drop_a_o     = drop_q[0];
    assign drop_b_o     = drop_q[1];

endmodule

// File: tb/tb_hockey_input_arbiter.sv
// Directed bench for hockey_input_arbiter: payload vector table plus hand-written
// sequences for latency, glitch rejection, ties, drops, flush and mid-run reset.
module tb_hockey_input_arbiter;

    logic       clk;
    logic       rst;
    logic       btn_a_raw, btn_b_raw;
    logic [1:0] dir_a, dir_b;
    logic [2:0] y_a, y_b;
    logic       flush, accept;
    logic       req_valid, req_player, req_y_ok, drop_a, drop_b;
    logic [2:0] req_y;
    logic [1:0] req_dir;

    int errors = 0;
    int checks = 0;
    int drop_a_cnt = 0;
    int drop_b_cnt = 0;
    int snap;
    bit found;

    typedef struct {
        logic       player;
        logic [2:0] y;
        logic [1:0] dir;
        logic [2:0] exp_y;
        logic [1:0] exp_dir;
        logic       exp_ok;
    } vec_t;

    vec_t vecs [6];

    hockey_input_arbiter #(.DEBOUNCE_CYCLES(4), .Y_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_a_raw_i  (btn_a_raw),
        .btn_b_raw_i  (btn_b_raw),
        .dir_a_i      (dir_a),
        .dir_b_i      (dir_b),
        .y_a_i        (y_a),
        .y_b_i        (y_b),
        .flush_i      (flush),
        .accept_i     (accept),
        .req_valid_o  (req_valid),
        .req_player_o (req_player),
        .req_y_o      (req_y),
        .req_dir_o    (req_dir),
        .req_y_ok_o   (req_y_ok),
        .drop_a_o     (drop_a),
        .drop_b_o     (drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (drop_a) drop_a_cnt++;
        if (drop_b) drop_b_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic pl, input logic [2:0] y, input logic [1:0] dir, input int hold);
        if (pl) begin
            y_b = y; dir_b = dir; btn_b_raw = 1'b1;
        end else begin
            y_a = y; dir_a = dir; btn_a_raw = 1'b1;
        end
        repeat (hold) tick();
        btn_a_raw = 1'b0;
        btn_b_raw = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        found = 1'b0;
        while (n < budget && !found) begin
            if (req_valid) found = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: req_valid got 0 expected 1 within %0d cycles", name, budget);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 3'd0, 2'b00, 3'd0, 2'b00, 1'b1};
        vecs[1] = '{1'b0, 3'd4, 2'b10, 3'd4, 2'b10, 1'b1};
        vecs[2] = '{1'b0, 3'd5, 2'b11, 3'd5, 2'b00, 1'b0};
        vecs[3] = '{1'b1, 3'd6, 2'b11, 3'd6, 2'b00, 1'b0};
        vecs[4] = '{1'b1, 3'd7, 2'b01, 3'd7, 2'b01, 1'b0};
        vecs[5] = '{1'b1, 3'd2, 2'b10, 3'd2, 2'b10, 1'b1};

        rst = 1'b1;
        btn_a_raw = 1'b0; btn_b_raw = 1'b0;
        dir_a = '0; dir_b = '0; y_a = '0; y_b = '0;
        flush = 1'b0; accept = 1'b0;
        repeat (2) tick();
        check("rst_valid",  32'(req_valid),  0);
        check("rst_player", 32'(req_player), 0);
        check("rst_y",      32'(req_y),      0);
        check("rst_dir",    32'(req_dir),    0);
        check("rst_y_ok",   32'(req_y_ok),   0);
        check("rst_drops",  32'({drop_a, drop_b}), 0);
        rst = 1'b0;
        repeat (3) tick();

        // held press: exact latency and payload
        y_a = 3'd3; dir_a = 2'b01; btn_a_raw = 1'b1;
        repeat (7) tick();
        check("lat_before_edge7", 32'(req_valid), 0);
        tick();
        check("lat_at_edge7", 32'(req_valid), 1);
        check("t1_player", 32'(req_player), 0);
        check("t1_y",      32'(req_y),      3);
        check("t1_dir",    32'(req_dir),    1);
        check("t1_y_ok",   32'(req_y_ok),   1);
        accept = 1'b1; tick(); accept = 1'b0;
        check("t1_consumed", 32'(req_valid), 0);
        btn_a_raw = 1'b0;
        repeat (12) tick();

        // 3-cycle glitch rejected, 4-cycle press accepted once
        snap = drop_b_cnt;
        btn_b_raw = 1'b1;
        repeat (3) tick();
        btn_b_raw = 1'b0;
        repeat (15) tick();
        check("glitch_no_req",  32'(req_valid), 0);
        check("glitch_no_drop", 32'(drop_b_cnt - snap), 0);
        press(1'b1, 3'd2, 2'b10, 4);
        wait_valid("short_press_valid", 20);
        check("short_press_player", 32'(req_player), 1);
        check("short_press_y",      32'(req_y),      2);
        accept = 1'b1; tick(); accept = 1'b0;
        check("short_press_consumed", 32'(req_valid), 0);
        repeat (15) tick();
        check("short_press_single", 32'(req_valid), 0);

        // payload table
        accept = 1'b1;
        for (int i = 0; i < 6; i++) begin
            press(vecs[i].player, vecs[i].y, vecs[i].dir, 6);
            wait_valid($sformatf("vec%0d_valid", i), 20);
            check($sformatf("vec%0d_player", i), 32'(req_player), 32'(vecs[i].player));
            check($sformatf("vec%0d_y", i),      32'(req_y),      32'(vecs[i].exp_y));
            check($sformatf("vec%0d_dir", i),    32'(req_dir),    32'(vecs[i].exp_dir));
            check($sformatf("vec%0d_y_ok", i),   32'(req_y_ok),   32'(vecs[i].exp_ok));
            repeat (12) tick();
        end

        // simultaneous presses, accept held: A first, then B with no bubble; repeat flips order
        for (int r = 0; r < 2; r++) begin
            y_a = 3'd1; dir_a = 2'b01; y_b = 3'd2; dir_b = 2'b10;
            btn_a_raw = 1'b1; btn_b_raw = 1'b1;
            repeat (6) tick();
            btn_a_raw = 1'b0; btn_b_raw = 1'b0;
            wait_valid($sformatf("tie%0d_valid", r), 20);
            check($sformatf("tie%0d_first", r), 32'(req_player), (r == 0) ? 0 : 1);
            tick();
            check($sformatf("tie%0d_no_bubble", r), 32'(req_valid), 1);
            check($sformatf("tie%0d_second", r), 32'(req_player), (r == 0) ? 1 : 0);
            tick();
            check($sformatf("tie%0d_drained", r), 32'(req_valid), 0);
            repeat (12) tick();
        end
        accept = 1'b0;

        // A pending while A already in the request register: third press drops
        press(1'b0, 3'd1, 2'b01, 6);
        repeat (12) tick();
        check("drop_first_valid", 32'(req_valid), 1);
        snap = drop_a_cnt;
        press(1'b0, 3'd2, 2'b10, 6);
        repeat (12) tick();
        check("drop_none_on_second", 32'(drop_a_cnt - snap), 0);
        press(1'b0, 3'd3, 2'b01, 6);
        repeat (12) tick();
        check("drop_a_once", 32'(drop_a_cnt - snap), 1);
        check("drop_hold_y",   32'(req_y),   1);
        check("drop_hold_dir", 32'(req_dir), 1);
        accept = 1'b1; tick(); accept = 1'b0;
        check("drop_next_valid", 32'(req_valid), 1);
        check("drop_next_y",     32'(req_y),     2);
        check("drop_next_dir",   32'(req_dir),   2);
        accept = 1'b1; tick(); accept = 1'b0;
        check("drop_drained", 32'(req_valid), 0);
        repeat (5) tick();

        // flush clears the request register and the pending B slot
        press(1'b0, 3'd3, 2'b01, 6);
        repeat (12) tick();
        check("flush_pre_valid", 32'(req_valid), 1);
        press(1'b1, 3'd4, 2'b00, 6);
        repeat (12) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_valid", 32'(req_valid), 0);
        check("flush_y_ok",  32'(req_y_ok),  0);
        repeat (15) tick();
        check("flush_slot_cleared", 32'(req_valid), 0);

        // async reset with A in the register and B pending; B still held afterwards
        press(1'b0, 3'd1, 2'b01, 6);
        repeat (12) tick();
        check("rst6_pre_valid", 32'(req_valid), 1);
        y_b = 3'd5; dir_b = 2'b01; btn_b_raw = 1'b1;
        repeat (9) tick();
        #2 rst = 1'b1;
        #1;
        check("rst6_valid",  32'(req_valid),  0);
        check("rst6_player", 32'(req_player), 0);
        check("rst6_y",      32'(req_y),      0);
        check("rst6_dir",    32'(req_dir),    0);
        check("rst6_y_ok",   32'(req_y_ok),   0);
        #2 rst = 1'b0;
        repeat (7) tick();
        check("rst6_before_edge7", 32'(req_valid), 0);
        tick();
        check("rst6_fresh_valid",  32'(req_valid),  1);
        check("rst6_fresh_player", 32'(req_player), 1);
        check("rst6_fresh_y",      32'(req_y),      5);
        check("rst6_fresh_y_ok",   32'(req_y_ok),   0);
        accept = 1'b1; tick(); accept = 1'b0;
        check("rst6_consumed", 32'(req_valid), 0);
        repeat (15) tick();
        check("rst6_single", 32'(req_valid), 0);
        btn_b_raw = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
